// File: rtl/result_sel_pkg.sv
// Shared types and source-index constants for the result select register.
// Imported by result_mux and result_select_reg.
package result_sel_pkg;

    typedef enum logic {
        RS_IDLE = 1'b0,
        RS_WAIT = 1'b1
    } rs_state_t;

    localparam int SRC_LO    = 0;
    localparam int SRC_HI    = 1;
    localparam int SRC_LT    = 2;
    localparam int SRC_ALU   = 3;
    localparam int SRC_OR    = 4;
    localparam int SRC_SHIFT = 5;

endpackage

// File: rtl/result_mux.sv
// Combinational N-way result source multiplexer.
// An index at or beyond NSRC selects zero.
module result_mux
    import result_sel_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NSRC  = 6,
    parameter int SELW  = $clog2(NSRC)
) (
    input  logic [NSRC*WIDTH-1:0] i_data,
    input  logic [SELW-1:0]       i_sel,
    output logic [WIDTH-1:0]      o_data
);

    // Pick the indexed slice; no match leaves the zero default
    always_comb begin
        o_data = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (int'(i_sel) == k) begin
                o_data = i_data[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/result_select_reg.sv
// Registered result-source select with ready-wait and done handshake.
// Optional wait timeout enabled by defining RESULT_SEL_TIMEOUT_EN.
module result_select_reg
    import result_sel_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NSRC    = 6,
    parameter int SELW    = $clog2(NSRC),
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_i,
    input  logic [SELW-1:0]       sel_i,
    input  logic [NSRC*WIDTH-1:0] src_data_i,
    input  logic [NSRC-1:0]       src_ready_i,
    output logic [WIDTH-1:0]      out_o,
    output logic                  done_o,
    output logic                  busy_o,
    output logic                  invalid_o,
    output logic                  timeout_o
);

    rs_state_t        r_state;
    logic [SELW-1:0]  r_sel;
    logic [WIDTH-1:0] r_out;
    logic             r_done;
    logic             r_busy;
    logic             r_invalid;

    logic [SELW-1:0]  w_idx;
    logic [WIDTH-1:0] w_mux;
    logic             w_rdy;
    logic             w_in_range;

`ifdef RESULT_SEL_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT) + 1;
    logic [CNTW-1:0] r_cnt;
    logic            r_timeout;
`endif

    assign w_idx = (r_state == RS_WAIT) ? r_sel : sel_i;

    result_mux #(
        .WIDTH (WIDTH),
        .NSRC  (NSRC),
        .SELW  (SELW)
    ) u_mux (
        .i_data (src_data_i),
        .i_sel  (w_idx),
        .o_data (w_mux)
    );

    // Ready flag and range check for the currently addressed source
    always_comb begin
        w_rdy      = 1'b0;
        w_in_range = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            if (int'(w_idx) == k) begin
                w_rdy      = src_ready_i[k];
                w_in_range = 1'b1;
            end
        end
    end

    // Capture FSM: accept request, wait for source, pulse done
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= RS_IDLE;
            r_sel     <= '0;
            r_out     <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_invalid <= 1'b0;
`ifdef RESULT_SEL_TIMEOUT_EN
            r_cnt     <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
            r_done    <= 1'b0;
            r_invalid <= 1'b0;
`ifdef RESULT_SEL_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            unique case (r_state)
                RS_IDLE: begin
                    if (req_i) begin
                        r_sel <= sel_i;
                        if (!w_in_range) begin
                            r_out     <= '0;
                            r_done    <= 1'b1;
                            r_invalid <= 1'b1;
                        end else if (w_rdy) begin
                            r_out  <= w_mux;
                            r_done <= 1'b1;
                        end else begin
                            r_state <= RS_WAIT;
                            r_busy  <= 1'b1;
`ifdef RESULT_SEL_TIMEOUT_EN
                            r_cnt   <= '0;
`endif
                        end
                    end
                end
                RS_WAIT: begin
                    if (w_rdy) begin
                        r_out   <= w_mux;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= RS_IDLE;
`ifdef RESULT_SEL_TIMEOUT_EN
                    end else if (r_cnt == CNTW'(TIMEOUT - 1)) begin
                        r_out     <= '0;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= RS_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
`endif
                    end
                end
                default: r_state <= RS_IDLE;
            endcase
        end
    end

    assign out_o     = r_out;
    assign done_o    = r_done;
    assign busy_o    = r_busy;
    assign invalid_o = r_invalid;

`ifdef RESULT_SEL_TIMEOUT_EN
    assign timeout_o = r_timeout;
`else
    // No wait limit in this build; TIMEOUT is referenced only here
    assign timeout_o = 1'b0 & (TIMEOUT > 0);
`endif

endmodule

// File: tb/tb_result_select_reg.sv
// Self-checking bench for result_select_reg.
// Vector table plus wait, reset-abort and timeout sequences.
module tb_result_select_reg;
    import result_sel_pkg::*;

    localparam int W = 32;
    localparam int N = 6;
    localparam int S = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic           req_i;
    logic [S-1:0]   sel_i;
    logic [N*W-1:0] src;
    logic [N-1:0]   rdy;
    logic [W-1:0]   out_o;
    logic           done_o;
    logic           busy_o;
    logic           invalid_o;
    logic           timeout_o;

    int n_run  = 0;
    int n_fail = 0;
    int busy_cnt;

    typedef struct {
        logic         req;
        logic [S-1:0] sel;
        logic [N-1:0] rdy;
        logic [W-1:0] out;
        logic         done;
        logic         busy;
        logic         inv;
    } vec_t;

    vec_t tv[8];

    result_select_reg #(
        .WIDTH   (W),
        .NSRC    (N),
        .TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req_i),
        .sel_i       (sel_i),
        .src_data_i  (src),
        .src_ready_i (rdy),
        .out_o       (out_o),
        .done_o      (done_o),
        .busy_o      (busy_o),
        .invalid_o   (invalid_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        req_i = 1'b0;
        sel_i = '0;
        rdy   = '1;
        src[SRC_LO*W    +: W] = 32'h1111_1111;
        src[SRC_HI*W    +: W] = 32'h2222_2222;
        src[SRC_LT*W    +: W] = 32'h0000_0001;
        src[SRC_ALU*W   +: W] = 32'hDEAD_BEEF;
        src[SRC_OR*W    +: W] = 32'h0F0F_00FF;
        src[SRC_SHIFT*W +: W] = 32'h8000_0000;

        tv[0] = '{1'b1, 3'd3, 6'h3F, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0};
        tv[1] = '{1'b0, 3'd3, 6'h3F, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0};
        tv[2] = '{1'b1, 3'd7, 6'h3F, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        tv[3] = '{1'b1, 3'd4, 6'h3F, 32'h0F0F_00FF, 1'b1, 1'b0, 1'b0};
        tv[4] = '{1'b1, 3'd5, 6'h3F, 32'h8000_0000, 1'b1, 1'b0, 1'b0};
        tv[5] = '{1'b0, 3'd0, 6'h3F, 32'h8000_0000, 1'b0, 1'b0, 1'b0};
        tv[6] = '{1'b1, 3'd2, 6'h3F, 32'h0000_0001, 1'b1, 1'b0, 1'b0};
        tv[7] = '{1'b1, 3'd1, 6'h3F, 32'h2222_2222, 1'b1, 1'b0, 1'b0};

        tick;
        tick;
        chk("rst_out", out_o, 32'h0);
        chk("rst_done", {31'b0, done_o}, 32'h0);
        chk("rst_busy", {31'b0, busy_o}, 32'h0);
        chk("rst_inv", {31'b0, invalid_o}, 32'h0);
        chk("rst_tmo", {31'b0, timeout_o}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            req_i = tv[i].req;
            sel_i = tv[i].sel;
            rdy   = tv[i].rdy;
            tick;
            chk($sformatf("v%0d_out", i), out_o, tv[i].out);
            chk($sformatf("v%0d_done", i), {31'b0, done_o},
                {31'b0, tv[i].done});
            chk($sformatf("v%0d_busy", i), {31'b0, busy_o},
                {31'b0, tv[i].busy});
            chk($sformatf("v%0d_inv", i), {31'b0, invalid_o},
                {31'b0, tv[i].inv});
            chk($sformatf("v%0d_tmo", i), {31'b0, timeout_o}, 32'h0);
        end

        // Wait on source 0: ready low for request + 5 WAIT cycles
        req_i = 1'b1;
        sel_i = 3'd0;
        rdy   = 6'b111110;
        tick;
        busy_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (busy_o) busy_cnt++;
            chk("wait_done", {31'b0, done_o}, 32'h0);
            req_i = i[0];
            sel_i = 3'd3;
            tick;
        end
        if (busy_o) busy_cnt++;
        src[SRC_LO*W +: W] = 32'h1234_5678;
        rdy = 6'b111111;
        req_i = 1'b0;
        tick;
        chk("wait_busy_cycles", busy_cnt, 32'd6);
        chk("wait_out", out_o, 32'h1234_5678);
        chk("wait_done_pulse", {31'b0, done_o}, 32'h1);
        chk("wait_busy_fall", {31'b0, busy_o}, 32'h0);
        src[SRC_LO*W +: W] = 32'hFFFF_FFFF;
        tick;
        chk("hold_out", out_o, 32'h1234_5678);
        chk("hold_done", {31'b0, done_o}, 32'h0);

        // Reset during the third WAIT cycle
        req_i = 1'b1;
        sel_i = 3'd1;
        rdy   = 6'b111101;
        tick;
        req_i = 1'b0;
        chk("abort_busy", {31'b0, busy_o}, 32'h1);
        tick;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("abort_out", out_o, 32'h0);
        chk("abort_done", {31'b0, done_o}, 32'h0);
        chk("abort_busy0", {31'b0, busy_o}, 32'h0);
        rdy   = 6'b111111;
        req_i = 1'b1;
        sel_i = 3'd3;
        tick;
        req_i = 1'b0;
        chk("after_abort_out", out_o, 32'hDEAD_BEEF);
        chk("after_abort_done", {31'b0, done_o}, 32'h1);

`ifdef RESULT_SEL_TIMEOUT_EN
        req_i = 1'b1;
        sel_i = 3'd0;
        rdy   = 6'b111110;
        tick;
        req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("tmo_wait_done", {31'b0, done_o}, 32'h0);
            tick;
        end
        chk("tmo_done", {31'b0, done_o}, 32'h1);
        chk("tmo_flag", {31'b0, timeout_o}, 32'h1);
        chk("tmo_out", out_o, 32'h0);
        chk("tmo_busy", {31'b0, busy_o}, 32'h0);

        req_i = 1'b1;
        tick;
        req_i = 1'b0;
        tick;
        tick;
        tick;
        rdy = 6'b111111;
        tick;
        chk("late_done", {31'b0, done_o}, 32'h1);
        chk("late_tmo", {31'b0, timeout_o}, 32'h0);
        chk("late_out", out_o, 32'hFFFF_FFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/result_select_reg.md
# result_select_reg

Parametrised, registered successor to the datapath's result-source multiplexer. It selects one of `NSRC` result sources (Lo, Hi, LT, ALU result, OR, shift, …) and latches the chosen value into an output register. When the selected source is multi-cycle (mult/div Hi/Lo), it waits for that source's ready flag before capturing. It sits between the functional units and the ALUOut/writeback register, and hands the control unit a request/done handshake instead of a fixed-cycle assumption.

## Interface
Parameters:
- `WIDTH`, 32, data width of every source and of the output.
- `NSRC`, 6, number of result sources.
- `SELW`, `$clog2(NSRC)`, select width (derived; not overridden).
- `TIMEOUT`, 64, maximum wait cycles; used only with `RESULT_SEL_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_i` in 1: capture request, sampled in IDLE only.
- `sel_i` in `SELW`: source index, sampled with `req_i`.
- `src_data_i` in `NSRC*WIDTH`: flattened sources; source k occupies bits `[k*WIDTH +: WIDTH]`.
- `src_ready_i` in `NSRC`: per-source data-valid; tie to 1 for combinational units.
- `out_o` out `WIDTH`: captured result; holds between captures.
- `done_o` out 1: one-cycle pulse, `out_o` updated.
- `busy_o` out 1: high while waiting for a source.
- `invalid_o` out 1: pulses with `done_o` when `sel_i >= NSRC`.
- `timeout_o` out 1: pulses with `done_o` on timeout abort; tied 0 without the macro.

## Operation
- Reset values: state IDLE, `out_o`=0, `done_o`=0, `busy_o`=0, `invalid_o`=0, `timeout_o`=0, `sel_q`=0, wait counter=0.
- States: IDLE, WAIT.
- IDLE with `req_i`=1: `sel_q` ← `sel_i`. Three cases:
  - `sel_i >= NSRC`: `out_o` ← 0, `done_o` and `invalid_o` pulse, stay IDLE.
  - `src_ready_i[sel_i]`=1: `out_o` ← selected source, `done_o` pulses, stay IDLE.
  - Otherwise: go to WAIT, `busy_o` ← 1, counter ← 0.
- WAIT:
  - `src_ready_i[sel_q]`=1: `out_o` ← `src_data_i[sel_q]`, `done_o` pulses, `busy_o` ← 0, go to IDLE.
  - `req_i` and `sel_i` are ignored in WAIT.
- IDLE with `req_i`=0: all outputs hold, except the pulse outputs (`done_o`, `invalid_o`, `timeout_o`), which return to 0.
- `done_o` is high in IDLE, so a new `req_i` in that cycle is accepted (back-to-back).
- Reset asserted in WAIT aborts the wait with no `done_o`. All outputs take their reset values at that edge.
- Source data is sampled only at the capture edge. Changes to `src_data_i` afterwards do not affect `out_o`.

## Timing
- Ready source: `req_i` in cycle 0 → `out_o` valid and `done_o`=1 in cycle 1. Latency 1.
- Waiting source: ready first seen high in WAIT cycle n → `out_o` and `done_o` in cycle n+1.
- `busy_o` is registered. It rises the cycle after an unready request and falls in the same cycle `done_o` rises.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- `RESULT_SEL_TIMEOUT_EN` defined:
  - The counter increments each WAIT cycle.
  - On the WAIT cycle where counter = `TIMEOUT-1` and ready is still low, the next edge does the following: `out_o` ← 0, `done_o` and `timeout_o` pulse, go to IDLE.
  - If ready and the limit occur in the same cycle, ready wins and normal capture applies.
- Not defined: no counter logic, WAIT lasts until ready, `timeout_o` is constant 0.

## Structure
- Package `result_sel_pkg`: state enum `rs_state_t {RS_IDLE, RS_WAIT}` and source index constants `SRC_LO`=0, `SRC_HI`=1, `SRC_LT`=2, `SRC_ALU`=3, `SRC_OR`=4, `SRC_SHIFT`=5.
- Sub-module `result_mux`: purely combinational, parameterised by `WIDTH`/`NSRC`. Takes a flattened input and an index, and outputs 0 for an out-of-range index. It is instantiated once, driven by `sel_i` in IDLE and `sel_q` in WAIT.

## Test plan
- Reset, then `req_i` with `sel_i`=3, source 3 = 0xDEADBEEF, all ready → cycle 1: `out_o`=0xDEADBEEF, `done_o`=1 for one cycle, `busy_o`=0.
- `sel_i`=0 with `src_ready_i[0]`=0 for 5 cycles, then 1 with source 0 = 0x12345678 → `busy_o` high for 6 cycles; `done_o` and `out_o`=0x12345678 on the cycle after ready; `req_i` pulses during WAIT are ignored.
- `sel_i`=7 (NSRC=6) → next cycle: `out_o`=0, `done_o`=1, `invalid_o`=1.
- Back-to-back: `req_i` held high with sel 4 then sel 5, both ready → consecutive `done_o` pulses with the OR value then the shift value.
- Reset asserted in the 3rd WAIT cycle → no `done_o`, all outputs 0 on the next cycle, and a subsequent request behaves normally.
- With `RESULT_SEL_TIMEOUT_EN` and `TIMEOUT`=4, ready never rises → after 4 WAIT cycles, `done_o`=`timeout_o`=1 and `out_o`=0; with ready rising on the 4th WAIT cycle → normal capture, `timeout_o`=0.
